// File: rtl/pe_column_drain_if.sv
// Result stream from a PE column drain toward the output writer.
// master: the drain (produces data/row/valid, consumes ready).
// slave: the consumer.
interface pe_column_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8
);
  localparam int ROW_W = $clog2(NUM_ROWS);

  logic [DATA_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]      out_row;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_row,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pe_column_drain.sv
// Output stage below one systolic PE column.
// It sequences LOAD -> SHIFT(NUM_ROWS) -> CLEAR on the column's mac_out chain.
// It captures each shifted result into a first-word-fall-through FIFO tagged
// with its row index, and presents the FIFO head on a valid/ready stream.
// Optional build macro PE_DRAIN_RELU_EN: negative heads read out as zero.
// The FIFO always stores raw values.
module pe_column_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          start_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          write_out_en,
  output logic                          reset_pe,
  input  logic signed [DATA_WIDTH-1:0]  chain_in,
  pe_column_drain_if.master             out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Last shift index; also the row tag of the first value out of the chain.
  localparam logic [ROW_W-1:0] LAST_K     = ROW_W'(NUM_ROWS - 1);
  // Largest occupancy that still leaves room for a whole column.
  localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(FIFO_DEPTH - NUM_ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CLEAR
  } state_t;

  state_t                          state_q, state_d;
  logic [ROW_W-1:0]                cnt_q, cnt_d;

  logic                            start_ready_q, start_ready_d;
  logic                            busy_q, done_q, woe_q, reset_pe_q;

  logic [CNT_W-1:0]                count_q, count_d;
  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
  logic                            out_valid_q;
  logic signed [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ROW_W-1:0]                out_row_q, out_row_d;

  logic signed [DATA_WIDTH-1:0]    mem_data_q [FIFO_DEPTH];
  logic [ROW_W-1:0]                mem_row_q  [FIFO_DEPTH];

  logic                            push, pop, bypass;
  logic [ROW_W-1:0]                push_row;
  logic signed [DATA_WIDTH-1:0]    head_data;
  logic [ROW_W-1:0]                head_row;

  // Read-side clamp; identity unless the ReLU build option is compiled in.
  function automatic logic signed [DATA_WIDTH-1:0] read_clamp(
    input logic signed [DATA_WIDTH-1:0] v
  );
`ifdef PE_DRAIN_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Drain sequencing: next state and shift counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && start_ready_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == LAST_K) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO bookkeeping and the next registered head.
  // Room for the push was reserved when the drain was accepted.
  always_comb begin
    push     = (state_q == S_SHIFT);
    push_row = LAST_K - cnt_q;
    pop      = out_valid_q & out_if.out_ready;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    // The entry being written now becomes the head when nothing else remains.
    bypass   = push && (count_q == CNT_W'(pop));
    if (bypass) begin
      head_data = chain_in;
      head_row  = push_row;
    end else begin
      head_data = mem_data_q[rd_ptr_d];
      head_row  = mem_row_q[rd_ptr_d];
    end
    if (count_d == '0) begin
      out_data_d = '0;
      out_row_d  = '0;
    end else begin
      out_data_d = read_clamp(head_data);
      out_row_d  = head_row;
    end
    start_ready_d = (state_d == S_IDLE) && (count_d <= ACCEPT_MAX);
  end

  // State, registered controls and FIFO pointers/head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      woe_q         <= 1'b0;
      reset_pe_q    <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_ready_q <= start_ready_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_CLEAR);
      woe_q         <= (state_d == S_SHIFT);
      reset_pe_q    <= (state_d == S_CLEAR);
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      out_valid_q   <= (count_d != '0);
      out_data_q    <= out_data_d;
      out_row_q     <= out_row_d;
    end
  end

  // FIFO storage: raw chain values with their row tags.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= chain_in;
      mem_row_q[wr_ptr_q]  <= push_row;
    end
  end

  assign start_ready      = start_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign write_out_en     = woe_q;
  assign reset_pe         = reset_pe_q;
  assign fifo_count       = count_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_row   = out_row_q;

endmodule

// File: tb/tb_pe_column_drain.sv
// Bench for pe_column_drain with a behavioural PE column around it.
// Expected stream contents and timing come from a schedule model.
// When a drain is accepted in cycle c, row NUM_ROWS-1-k becomes visible at
// cycle c+3+k, and the column is busy over c+1..c+10.
module tb_pe_column_drain;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int FD = 16;
  localparam int CW = 5;
`ifdef PE_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    int          t;
    logic [2:0]  row;
    logic [15:0] data;
  } item_t;

  typedef struct {
    logic [2:0]  row;
    logic [15:0] acc_in;
    logic [15:0] exp_out;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start_ready, busy, done, write_out_en, reset_pe;
  logic [DW-1:0] chain_in;
  logic [CW-1:0] fifo_count;

  pe_column_drain_if #(.DATA_WIDTH(DW), .NUM_ROWS(NR)) oif ();

  pe_column_drain #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_ready  (start_ready),
    .busy         (busy),
    .done         (done),
    .write_out_en (write_out_en),
    .reset_pe     (reset_pe),
    .chain_in     (chain_in),
    .out_if       (oif.master),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural PE column: accumulators plus the mac_out shift chain.
  logic [DW-1:0] acc [NR];
  logic [DW-1:0] mac [NR];
  logic [DW-1:0] load_vals [NR];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (reset_pe) acc[r] <= '0;
      else if (load_req) acc[r] <= load_vals[r];
    end
    if (write_out_en) begin
      mac[0] <= '0;
      for (int r = 1; r < NR; r++) mac[r] <= mac[r-1];
    end else begin
      for (int r = 0; r < NR; r++) mac[r] <= acc[r];
    end
  end
  assign chain_in = mac[NR-1];

  // Reference model state.
  int            cyc = 0;
  int            last_acc = -100;
  int            tests = 0;
  int            fails = 0;
  item_t         pend[$];
  item_t         vis[$];
  item_t         got[$];
  logic [DW-1:0] model_acc [NR];
  vec_t          tbl [NR];

  function automatic logic [15:0] clamp(input logic [15:0] v);
    if (RELU && v[15]) return 16'h0000;
    return v;
  endfunction

  function automatic bit m_busy(input int c);
    return (c >= last_acc + 1) && (c <= last_acc + 10);
  endfunction

  function automatic bit m_sr();
    return !m_busy(cyc) && ((FD - vis.size()) >= NR);
  endfunction

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    vis.delete();
    last_acc = -100;
  endtask

  // Close the current cycle with the inputs already driven.
  // Then move to #1 after the next edge and compare every output.
  task automatic step();
    if (!rst) begin
      if (start && m_sr()) begin
        for (int k = 0; k < NR; k++)
          pend.push_back('{t: cyc + 3 + k, row: 3'(NR - 1 - k), data: clamp(model_acc[NR-1-k])});
        last_acc = cyc;
      end
      if (oif.out_ready && vis.size() != 0) begin
        got.push_back('{t: cyc, row: oif.out_row, data: oif.out_data});
        void'(vis.pop_front());
      end
      if (load_req) model_acc = load_vals;
      if (cyc == last_acc + 10) foreach (model_acc[i]) model_acc[i] = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    while (pend.size() != 0 && pend[0].t <= cyc) vis.push_back(pend.pop_front());
    check("write_out_en", write_out_en, (cyc >= last_acc + 2) && (cyc <= last_acc + 9));
    check("reset_pe", reset_pe, cyc == last_acc + 10);
    check("done", done, cyc == last_acc + 10);
    check("busy", busy, m_busy(cyc));
    check("start_ready", start_ready, m_sr());
    check("fifo_count", fifo_count, vis.size());
    check("out_valid", oif.out_valid, vis.size() != 0);
    if (vis.size() != 0) begin
      check("out_data", oif.out_data, vis[0].data);
      check("out_row", oif.out_row, vis[0].row);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rstep();
    oif.out_ready = 1'($urandom_range(0, 1));
    start = ($urandom_range(0, 7) == 0);
    step();
    start = 1'b0;
  endtask

  task automatic load_column();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((m_busy(cyc) || vis.size() != 0 || pend.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_within_bound", n < 200, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int woe_n, done_n, done_at, c0, w;

    tbl[0] = '{3'd7, 16'hFFFB, RELU ? 16'h0000 : 16'hFFFB};
    tbl[1] = '{3'd6, 16'h0007, 16'h0007};
    tbl[2] = '{3'd5, 16'h8000, RELU ? 16'h0000 : 16'h8000};
    tbl[3] = '{3'd4, 16'h7FFF, 16'h7FFF};
    tbl[4] = '{3'd3, 16'hFFFF, RELU ? 16'h0000 : 16'hFFFF};
    tbl[5] = '{3'd2, 16'h0000, 16'h0000};
    tbl[6] = '{3'd1, 16'h0001, 16'h0001};
    tbl[7] = '{3'd0, 16'hC350, RELU ? 16'h0000 : 16'hC350};

    oif.out_ready = 1'b0;
    foreach (load_vals[i]) load_vals[i] = '0;

    // Reset, then quiet idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_out_valid", oif.out_valid, 0);
    check("rst_write_out_en", write_out_en, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_reset_pe", reset_pe, 0);
    check("rst_out_data", oif.out_data, 0);
    check("rst_out_row", oif.out_row, 0);
    rst = 1'b0;
    idle(20);

    // Basic drain of 10..80 with the consumer always ready.
    oif.out_ready = 1'b1;
    foreach (load_vals[i]) load_vals[i] = 16'(10 * (i + 1));
    load_column();
    got.delete();
    woe_n = 0;
    done_n = 0;
    done_at = -1;
    c0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      start = 1'b0;
      if (write_out_en) woe_n++;
      if (done) begin
        done_n++;
        done_at = cyc - c0;
      end
    end
    check("basic_woe_cycles", woe_n, 8);
    check("basic_done_pulses", done_n, 1);
    check("basic_done_cycle", done_at, 10);
    wait_drained();
    check("basic_stream_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check("basic_row", got[i].row, 7 - i);
      check("basic_data", got[i].data, 80 - 10 * i);
    end

    // Backpressure: two drains fill the FIFO, third start is dropped.
    oif.out_ready = 1'b0;
    load_column();
    do_start();
    idle(11);
    check("bp_count_8", fifo_count, 8);
    check("bp_ready_8", start_ready, 1);
    foreach (load_vals[i]) load_vals[i] = 16'(110 + 10 * i);
    load_column();
    do_start();
    idle(11);
    check("bp_count_16", fifo_count, 16);
    check("bp_ready_16", start_ready, 0);
    do_start();
    idle(2);
    check("bp_third_busy", busy, 0);
    check("bp_third_count", fifo_count, 16);
    oif.out_ready = 1'b1;
    idle(8);
    oif.out_ready = 1'b0;
    check("bp_after_pops_count", fifo_count, 8);
    check("bp_after_pops_ready", start_ready, 1);
    oif.out_ready = 1'b1;
    wait_drained();

    // Push and pop together with three entries queued, read pointer wrapping.
    foreach (load_vals[i]) load_vals[i] = 16'(200 + i);
    load_column();
    do_start();
    wait_drained();
    oif.out_ready = 1'b0;
    foreach (load_vals[i]) load_vals[i] = 16'(300 + i);
    load_column();
    do_start();
    idle(11);
    oif.out_ready = 1'b1;
    idle(5);
    oif.out_ready = 1'b0;
    check("pp_prequeued", fifo_count, 3);
    foreach (load_vals[i]) load_vals[i] = 16'(400 + i);
    load_column();
    do_start();
    step();
    oif.out_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      check("pp_count_shift", fifo_count, 3);
      step();
    end
    wait_drained();

    // Reset during SHIFT, then a clean drain.
    oif.out_ready = 1'b0;
    foreach (load_vals[i]) load_vals[i] = 16'(500 + i);
    load_column();
    do_start();
    idle(5);
    rst = 1'b1;
    #1;
    check("midrst_write_out_en", write_out_en, 0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_out_valid", oif.out_valid, 0);
    check("midrst_busy", busy, 0);
    model_reset();
    step();
    rst = 1'b0;
    oif.out_ready = 1'b1;
    got.delete();
    do_start();
    wait_drained();
    check("midrst_fresh_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("midrst_fresh_data", got[i].data, 16'(500 + 7 - i));

    // Sign boundary vectors.
    foreach (tbl[i]) load_vals[tbl[i].row] = tbl[i].acc_in;
    load_column();
    got.delete();
    do_start();
    wait_drained();
    check("tbl_len", got.size(), NR);
    for (int i = 0; i < NR && i < got.size(); i++) begin
      check("tbl_row", got[i].row, tbl[i].row);
      check("tbl_data", got[i].data, tbl[i].exp_out);
    end

    // Random traffic against the schedule model.
    for (int it = 0; it < 60; it++) begin
      w = $urandom_range(0, 4);
      repeat (w) rstep();
      if (!m_busy(cyc)) begin
        foreach (load_vals[i]) load_vals[i] = 16'($urandom);
        oif.out_ready = 1'($urandom_range(0, 1));
        load_column();
        oif.out_ready = 1'($urandom_range(0, 1));
        do_start();
      end
    end
    oif.out_ready = 1'b1;
    wait_drained();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
